// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-number generator / multiplier stage.
// Holds the control FSM state type, the random word width and the word rotation used for B.
package sc_pkg;

   localparam int SC_WORD_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } sc_state_e;

   // Swapping the word halves gives the B comparator a differently ordered draw,
   // so the A and B streams are not built from identical comparisons.
   function automatic logic [SC_WORD_W-1:0] rot_half(input logic [SC_WORD_W-1:0] r);
      return {r[SC_WORD_W/2-1:0], r[SC_WORD_W-1:SC_WORD_W/2]};
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/sc_cmp_lane4.sv
// Four parallel unsigned comparators: lane i is 1 when value exceeds random word i.
// Used once for the A stream and once, with rotated words, for the B stream.
module sc_cmp_lane4
   import sc_pkg::*;
(
   input  logic [SC_WORD_W-1:0] value,
   input  logic [SC_WORD_W-1:0] rnd_0,
   input  logic [SC_WORD_W-1:0] rnd_1,
   input  logic [SC_WORD_W-1:0] rnd_2,
   input  logic [SC_WORD_W-1:0] rnd_3,
   output logic [3:0]           bits
);

   logic [SC_WORD_W-1:0] words [4];

   assign words[0] = rnd_0;
   assign words[1] = rnd_1;
   assign words[2] = rnd_2;
   assign words[3] = rnd_3;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign bits[gi] = (value > words[gi]);
   end

endmodule

// File: rtl/sc_sng_mult_4x.sv
// Stochastic multiplier: latches two 4-bit operands, turns them into 4-bit-wide unipolar
// bitstreams against the LFSR words for NUM_CYCLES cycles, ANDs them and counts the ones.
module sc_sng_mult_4x
   import sc_pkg::*;
#(
   parameter int NUM_CYCLES = 4,
   parameter int CW         = $clog2(4*NUM_CYCLES+1)
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [SC_WORD_W-1:0] value_a,
   input  logic [SC_WORD_W-1:0] value_b,
   input  logic [SC_WORD_W-1:0] rnd1,
   input  logic [SC_WORD_W-1:0] rnd2,
   input  logic [SC_WORD_W-1:0] rnd3,
   input  logic [SC_WORD_W-1:0] rnd4,
   output logic                 busy,
   output logic [3:0]           stream_a,
   output logic [3:0]           stream_b,
   output logic [3:0]           stream_p,
   output logic                 stream_valid,
   output logic                 done,
   output logic [CW-1:0]        product_count
);

   localparam int              CNT_W    = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CYCLES - 1);

   sc_state_e            state_q, state_d;
   logic [SC_WORD_W-1:0] value_a_q, value_a_d;
   logic [SC_WORD_W-1:0] value_b_q, value_b_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           stream_a_q, stream_a_d;
   logic [3:0]           stream_b_q, stream_b_d;
   logic                 stream_valid_q, stream_valid_d;
   logic [CW-1:0]        product_count_q, product_count_d;

   logic [3:0]           cmp_a;
   logic [3:0]           cmp_b;

   sc_cmp_lane4 u_cmp_a (
      .value (value_a_q),
      .rnd_0 (rnd1),
      .rnd_1 (rnd2),
      .rnd_2 (rnd3),
      .rnd_3 (rnd4),
      .bits  (cmp_a)
   );

   sc_cmp_lane4 u_cmp_b (
      .value (value_b_q),
      .rnd_0 (rot_half(rnd1)),
      .rnd_1 (rot_half(rnd2)),
      .rnd_2 (rot_half(rnd3)),
      .rnd_3 (rot_half(rnd4)),
      .bits  (cmp_b)
   );

   always_comb begin
      state_d         = state_q;
      value_a_d       = value_a_q;
      value_b_d       = value_b_q;
      cnt_d           = cnt_q;
      stream_a_d      = 4'b0000;
      stream_b_d      = 4'b0000;
      stream_valid_d  = 1'b0;
      product_count_d = product_count_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               value_a_d       = value_a;
               value_b_d       = value_b;
               product_count_d = '0;
               cnt_d           = '0;
               state_d         = RUN;
            end
         end
         RUN: begin
            stream_a_d      = cmp_a;
            stream_b_d      = cmp_b;
            stream_valid_d  = 1'b1;
            // The count already includes the slice being registered on this edge,
            // so it is final exactly when that last slice becomes visible.
            product_count_d = product_count_q + CW'(popcount4(cmp_a & cmp_b));
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = LAST;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LAST: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         value_a_q       <= '0;
         value_b_q       <= '0;
         cnt_q           <= '0;
         stream_a_q      <= '0;
         stream_b_q      <= '0;
         stream_valid_q  <= 1'b0;
         product_count_q <= '0;
      end else begin
         state_q         <= state_d;
         value_a_q       <= value_a_d;
         value_b_q       <= value_b_d;
         cnt_q           <= cnt_d;
         stream_a_q      <= stream_a_d;
         stream_b_q      <= stream_b_d;
         stream_valid_q  <= stream_valid_d;
         product_count_q <= product_count_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == LAST);
   assign stream_a      = stream_a_q;
   assign stream_b      = stream_b_q;
   assign stream_p      = stream_a_q & stream_b_q;
   assign stream_valid  = stream_valid_q;
   assign product_count = product_count_q;

endmodule

// File: tb/tb_sc_sng_mult_4x.sv
// Scoreboard bench for sc_sng_mult_4x: directed operations push expected slices and counts,
// negedge monitors pop and compare whenever a DUT presents a valid slice or a done pulse.
module tb_sc_sng_mult_4x;

   localparam int CW4 = $clog2(4*4+1);
   localparam int CW1 = $clog2(4*1+1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic           start4;
   logic [3:0]     va4, vb4, r1, r2, r3, r4;
   logic           busy4, sv4, done4;
   logic [3:0]     sa4, sb4, sp4;
   logic [CW4-1:0] pc4;

   logic           start1;
   logic [3:0]     va1, vb1, q1, q2, q3, q4;
   logic           busy1, sv1, done1;
   logic [3:0]     sa1, sb1, sp1;
   logic [CW1-1:0] pc1;

   sc_sng_mult_4x #(.NUM_CYCLES(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .value_a(va4), .value_b(vb4),
      .rnd1(r1), .rnd2(r2), .rnd3(r3), .rnd4(r4),
      .busy(busy4), .stream_a(sa4), .stream_b(sb4), .stream_p(sp4),
      .stream_valid(sv4), .done(done4), .product_count(pc4)
   );

   sc_sng_mult_4x #(.NUM_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .value_a(va1), .value_b(vb1),
      .rnd1(q1), .rnd2(q2), .rnd3(q3), .rnd4(q4),
      .busy(busy1), .stream_a(sa1), .stream_b(sb1), .stream_p(sp1),
      .stream_valid(sv1), .done(done1), .product_count(pc1)
   );

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] p;
   } slice_t;

   slice_t sq4[$];
   slice_t sq1[$];
   int     cq4[$];
   int     cq1[$];
   int     checks = 0;
   int     errors = 0;
   int     done_seen4 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor for the NUM_CYCLES=4 instance.
   always @(negedge clk) begin
      slice_t e;
      int     ec;
      if (sv4) begin
         checks++;
         if (sq4.size() == 0) begin
            errors++;
            $display("FAIL slice4_unexpected actual a=%b b=%b p=%b required no slice", sa4, sb4, sp4);
         end else begin
            e = sq4.pop_front();
            if ({sa4, sb4, sp4} !== e) begin
               errors++;
               $display("FAIL slice4 actual a=%b b=%b p=%b required a=%b b=%b p=%b",
                        sa4, sb4, sp4, e.a, e.b, e.p);
            end
         end
      end
      if (done4) begin
         done_seen4++;
         chk("done4_with_valid", {31'd0, sv4}, 32'd1);
         checks++;
         if (cq4.size() == 0) begin
            errors++;
            $display("FAIL done4_unexpected actual count=%0d required no done", pc4);
         end else begin
            ec = cq4.pop_front();
            if (int'(pc4) != ec) begin
               errors++;
               $display("FAIL count4 actual=%0d required=%0d", pc4, ec);
            end
         end
         $display("dut4 op done count=%0d", pc4);
      end
   end

   // Monitor for the NUM_CYCLES=1 instance.
   always @(negedge clk) begin
      slice_t e;
      int     ec;
      if (sv1) begin
         checks++;
         if (sq1.size() == 0) begin
            errors++;
            $display("FAIL slice1_unexpected actual a=%b b=%b p=%b required no slice", sa1, sb1, sp1);
         end else begin
            e = sq1.pop_front();
            if ({sa1, sb1, sp1} !== e) begin
               errors++;
               $display("FAIL slice1 actual a=%b b=%b p=%b required a=%b b=%b p=%b",
                        sa1, sb1, sp1, e.a, e.b, e.p);
            end
         end
      end
      if (done1) begin
         chk("done1_with_valid", {31'd0, sv1}, 32'd1);
         checks++;
         if (cq1.size() == 0) begin
            errors++;
            $display("FAIL done1_unexpected actual count=%0d required no done", pc1);
         end else begin
            ec = cq1.pop_front();
            if (int'(pc1) != ec) begin
               errors++;
               $display("FAIL count1 actual=%0d required=%0d", pc1, ec);
            end
         end
         $display("dut1 op done count=%0d", pc1);
      end
   end

   // One NUM_CYCLES=4 operation. rnds holds cycle k in bits [16k +: 16] with rnd1 lowest;
   // ea/eb hold the hand-computed lane vectors for cycle k in bits [4k +: 4].
   task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic [63:0] rnds,
                          input logic [15:0] ea, input logic [15:0] eb, input int ecount);
      for (int k = 0; k < 4; k++)
         sq4.push_back({ea[4*k +: 4], eb[4*k +: 4], ea[4*k +: 4] & eb[4*k +: 4]});
      cq4.push_back(ecount);
      start4 = 1'b1;
      va4    = a;
      vb4    = b;
      tick();
      start4 = 1'b0;
      chk("busy_cycle1", {31'd0, busy4}, 32'd1);
      chk("count_cycle1", {27'd0, pc4}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         {r4, r3, r2, r1} = rnds[16*k +: 16];
         tick();
      end
      chk("done_cycle5", {31'd0, done4}, 32'd1);
      tick();
      chk("busy_cycle6", {31'd0, busy4}, 32'd0);
      chk("done_cycle6", {31'd0, done4}, 32'd0);
   endtask

   initial begin
      int d0;
      reset_n = 1'b0;
      start4 = 1'b0; va4 = '0; vb4 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0;
      start1 = 1'b0; va1 = '0; vb1 = '0; q1 = '0; q2 = '0; q3 = '0; q4 = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      chk("rst_busy",  {31'd0, busy4}, 32'd0);
      chk("rst_a",     {28'd0, sa4}, 32'd0);
      chk("rst_b",     {28'd0, sb4}, 32'd0);
      chk("rst_p",     {28'd0, sp4}, 32'd0);
      chk("rst_valid", {31'd0, sv4}, 32'd0);
      chk("rst_done",  {31'd0, done4}, 32'd0);
      chk("rst_count", {27'd0, pc4}, 32'd0);

      // Zero operands give empty streams regardless of the draws.
      run_op4(4'd0, 4'd0, 64'h0123_4567_89AB_CDEF, 16'h0000, 16'h0000, 0);
      // All 15 non-zero codes plus 2: only the single 15 draw (cycle 4, lane 2) gives 0.
      run_op4(4'd15, 4'd15, {16'h2FED, 16'hCBA9, 16'h8765, 16'h4321}, 16'hBFFF, 16'hBFFF, 15);
      // 8 > 7 everywhere; rot(7)=13 < 15.
      run_op4(4'd8, 4'd15, 64'h7777_7777_7777_7777, 16'hFFFF, 16'hFFFF, 16);
      // 8 > 8 is false; rot(8)=2 < 15.
      run_op4(4'd8, 4'd15, 64'h8888_8888_8888_8888, 16'h0000, 16'hFFFF, 0);

      // start held high: op1 5/10 (A=F, B: 10>rot(3)=12 false), op2 picks up 12/13 in cycle 6.
      {r4, r3, r2, r1} = 16'h3333;
      for (int k = 0; k < 4; k++) sq4.push_back({4'hF, 4'h0, 4'h0});
      for (int k = 0; k < 4; k++) sq4.push_back({4'hF, 4'hF, 4'hF});
      cq4.push_back(0);
      cq4.push_back(16);
      start4 = 1'b1;
      va4    = 4'd5;
      vb4    = 4'd10;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 2) begin
            va4 = 4'd12;
            vb4 = 4'd13;
         end
         if (k == 7) start4 = 1'b0;
         chk($sformatf("held_busy_c%0d", k), {31'd0, busy4}, (k == 6 || k == 12) ? 32'd0 : 32'd1);
         chk($sformatf("held_done_c%0d", k), {31'd0, done4}, (k == 5 || k == 11) ? 32'd1 : 32'd0);
      end

      // Reset in RUN cycle 3: only the cycle-2 slice is ever seen and no done.
      {r4, r3, r2, r1} = 16'h0000;
      sq4.push_back({4'hF, 4'hF, 4'hF});
      d0     = done_seen4;
      start4 = 1'b1;
      va4    = 4'd15;
      vb4    = 4'd15;
      tick();
      start4 = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("abort_busy",  {31'd0, busy4}, 32'd0);
      chk("abort_a",     {28'd0, sa4}, 32'd0);
      chk("abort_b",     {28'd0, sb4}, 32'd0);
      chk("abort_p",     {28'd0, sp4}, 32'd0);
      chk("abort_valid", {31'd0, sv4}, 32'd0);
      chk("abort_done",  {31'd0, done4}, 32'd0);
      chk("abort_count", {27'd0, pc4}, 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (4) tick();
      chk("abort_no_done", done_seen4, d0);
      run_op4(4'd8, 4'd15, 64'h7777_7777_7777_7777, 16'hFFFF, 16'hFFFF, 16);

      // NUM_CYCLES=1: 9/6 against 0,5,9,12 -> A=0011, B=1011 (rot: 0,5,6,3), count 2.
      sq1.push_back({4'b0011, 4'b1011, 4'b0011});
      cq1.push_back(2);
      start1 = 1'b1;
      va1    = 4'd9;
      vb1    = 4'd6;
      tick();
      start1 = 1'b0;
      chk("n1_busy_c1",  {31'd0, busy1}, 32'd1);
      chk("n1_valid_c1", {31'd0, sv1}, 32'd0);
      chk("n1_done_c1",  {31'd0, done1}, 32'd0);
      q1 = 4'd0; q2 = 4'd5; q3 = 4'd9; q4 = 4'd12;
      tick();
      chk("n1_busy_c2",  {31'd0, busy1}, 32'd1);
      chk("n1_valid_c2", {31'd0, sv1}, 32'd1);
      chk("n1_done_c2",  {31'd0, done1}, 32'd1);
      tick();
      chk("n1_busy_c3",  {31'd0, busy1}, 32'd0);
      chk("n1_valid_c3", {31'd0, sv1}, 32'd0);
      tick();

      chk("sq4_drained", sq4.size(), 0);
      chk("cq4_drained", cq4.size(), 0);
      chk("sq1_drained", sq1.size(), 0);
      chk("cq1_drained", cq1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_sng_mult_4x.md
# sc_sng_mult_4x

Stochastic-number generator and multiplier stage fed by the 4-lane parallel 4-bit LFSR. On a `start` request it latches two 4-bit binary operands. For a fixed number of cycles it converts them into 4-bit-wide parallel stochastic bitstreams by comparing against the four random words supplied each cycle. It ANDs the streams (unipolar multiply) and counts the product ones, giving a binary estimate of `value_a*value_b/256` scaled to the stream length.

## Interface
- `NUM_CYCLES`, default 4: RUN cycles per operation; stream length = 4*NUM_CYCLES bits; must be ≥1.
- `CW`, default $clog2(4*NUM_CYCLES+1): width of `product_count` (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: operation request, sampled only when `busy`=0.
- `value_a` in 4: operand A, unsigned, latched on accepted `start`.
- `value_b` in 4: operand B, unsigned, latched on accepted `start`.
- `rnd1`, `rnd2`, `rnd3`, `rnd4` in 4 each: the four random words for the current cycle (LFSR `random1..random4`).
- `busy` out 1: operation in progress.
- `stream_a` out 4: registered A-stream bits, lane i from `rnd(i+1)`.
- `stream_b` out 4: registered B-stream bits.
- `stream_p` out 4: `stream_a & stream_b`.
- `stream_valid` out 1: stream outputs carry a valid 4-bit slice.
- `done` out 1: one-cycle completion pulse.
- `product_count` out CW: ones count of all `stream_p` slices of the last/current operation.

## Operation
- FSM states: IDLE, RUN, LAST.
  - IDLE: `start`=1 → latch operands, clear `product_count`, clear cycle counter → RUN.
  - RUN: at each edge, register the slices, increment the counter, and add the popcount of the new `stream_p` to `product_count`. At the edge where the counter = NUM_CYCLES-1 → LAST.
  - LAST: unconditional → IDLE.
- Lane bits:
  - `stream_a[i] = (value_a_q > rnd(i+1))`, unsigned compare.
  - `stream_b[i] = (value_b_q > rot(rnd(i+1)))`, where `rot(r) = {r[1:0], r[3:2]}`. This decorrelates the B stream from the A stream.
- Operand 0 yields all-zero streams. Operand 15 yields 1 in every lane except where the compared word is 4'b1111.
- `product_count` saturation is impossible by construction: the maximum is 4*NUM_CYCLES.
- `start` while `busy`=1 is ignored, with no queueing. Operand changes after acceptance have no effect.
- Reset at any time, including mid-RUN, forces IDLE immediately. No `done` is produced for an aborted operation.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- `busy`: high cycles 1..NUM_CYCLES+1.
- RUN occupies cycles 1..NUM_CYCLES. The `rnd*` inputs present in RUN cycle k produce the slice visible in cycle k+1.
- `stream_valid`: high cycles 2..NUM_CYCLES+1. Exactly NUM_CYCLES slices per operation.
- `done`: high in cycle NUM_CYCLES+1 only, coincident with the last valid slice.
  - `product_count` is final in that cycle and held until the next accepted `start`.
  - `product_count` reads 0 in cycle 1.
- Earliest next `start` acceptance: cycle NUM_CYCLES+2, so back-to-back throughput is one operation per NUM_CYCLES+2 cycles.
- Reset values: `busy`=0, `stream_a/b/p`=0, `stream_valid`=0, `done`=0, `product_count`=0, internal operand and counter registers = 0.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.

## Structure
- Shared package `sc_pkg` holds:
  - the `sc_state_e` enum (IDLE, RUN, LAST);
  - the `SC_WORD_W` = 4 constant;
  - the `rot_half` function.
- One sub-module, `sc_cmp_lane4`: four parallel unsigned 4-bit comparators, with one value and four random words in and 4 bits out. It is instantiated twice, once for A and once with rotated words for B.
- Popcount and accumulator live in the top level.

## Test plan
- Operands 0/0, any `rnd` → all `stream_*` = 0 for 4 valid slices; `done` in cycle 5 with `product_count` = 0.
- Operands 15/15, `rnd` drives the 16 draws {all 15 non-zero codes once, plus 4'b0010} over 4 cycles → `product_count` = 15. The single 4'b1111 draw yields a 0 in A, B and P.
- Operands 8/15, constant `rnd` = 4'b0111 → every slice A = B = P = 4'b1111 and `product_count` = 16. Then `rnd` = 4'b1000 → A = 4'b0000 and `product_count` = 0.
- `start` held high continuously with NUM_CYCLES = 4 → accepts in cycles 0 and 6 only. `busy` drops for exactly cycle 6, with `done` pulses in cycles 5 and 11. Operand change in cycle 2 is ignored.
- `reset_n` low in cycle 3 of RUN → all outputs 0 asynchronously and no `done`. After release, a new `start` runs a clean operation with a correct count.
- NUM_CYCLES = 1 → `busy` in cycles 1–2, one valid slice in cycle 2, `done` in cycle 2.
